// File: rtl/r22sdf_bitrev_reorder.sv
// Purpose : reorders bit-reversed FFT output frames into natural bin order via a ping-pong RAM.
// Latency : first natural-order sample appears 2 cycles after the last input sample of a frame.
// Backpr. : none; streams 1 sample/cycle in and out, sys_en freezes everything.
//
// Ports:
//   sys_clk, sys_nrst     clock (rising edge), asynchronous active-low reset
//   sys_en                global clock enable; low freezes all state and outputs
//   din_valid/din_sof     input sample strobe / first bit-reversed sample of a frame
//   din_r/din_i           input sample (bit-reversed order)
//   dout_valid/sof/eof    output strobe / natural bin 0 / natural bin N-1
//   dout_r/dout_i         output sample (natural order), held while not valid
//   frame_err             one-cycle pulse on a restart-mid-frame or overrun fault
module r22sdf_bitrev_reorder #(
  parameter int data_resolution = 16,
  parameter int fft_length      = 16384
) (
  input  logic                       sys_clk,
  input  logic                       sys_nrst,
  input  logic                       sys_en,
  input  logic                       din_valid,
  input  logic                       din_sof,
  input  logic [data_resolution-1:0] din_r,
  input  logic [data_resolution-1:0] din_i,
  output logic                       dout_valid,
  output logic                       dout_sof,
  output logic                       dout_eof,
  output logic [data_resolution-1:0] dout_r,
  output logic [data_resolution-1:0] dout_i,
  output logic                       frame_err
);

  localparam int addr_w = $clog2(fft_length);
  localparam logic [addr_w-1:0] last_idx = addr_w'(fft_length - 1);
  localparam logic [addr_w-1:0] one_idx  = addr_w'(1);

  typedef enum logic { WAIT_SOF, FILL } wr_state_t;
  typedef enum logic { IDLE, READ }     rd_state_t;

  // Reverse all addr_w bits of an index.
  function automatic logic [addr_w-1:0] bitrev(input logic [addr_w-1:0] a);
    logic [addr_w-1:0] r;
    for (int b = 0; b < addr_w; b++) begin
      r[b] = a[addr_w-1-b];
    end
    return r;
  endfunction

  // Write side state
  wr_state_t         wr_state, wr_state_nxt;
  logic [addr_w-1:0] wr_cnt, wr_cnt_nxt;
  logic              wr_bank, wr_bank_nxt;
  logic              wr_en;
  logic [addr_w-1:0] wr_addr;
  logic              wr_done;
  logic              err_nxt;

  // Read side state
  rd_state_t         rd_state, rd_state_nxt;
  logic [addr_w-1:0] rd_cnt, rd_cnt_nxt;
  logic              rd_bank, rd_bank_nxt;
  logic              rd_en;
  logic              rd_done;

  logic [1:0]        bank_full, bank_full_nxt;

  // Two banks of N complex words; bank select is the address MSB.
  logic [2*data_resolution-1:0] mem [0:2*fft_length-1];

  // ---------------------------------------------------------------
  // Write FSM: scatter incoming bit-reversed samples to natural slots
  // ---------------------------------------------------------------
  always_comb begin
    wr_state_nxt = wr_state;
    wr_cnt_nxt   = wr_cnt;
    wr_bank_nxt  = wr_bank;
    wr_en        = 1'b0;
    wr_addr      = bitrev(wr_cnt);
    wr_done      = 1'b0;
    err_nxt      = 1'b0;
    case (wr_state)
      WAIT_SOF: begin
        if (din_valid && din_sof) begin
          if (bank_full[wr_bank]) begin
            // Overrun: the target bank is still unread, drop this frame.
            err_nxt = 1'b1;
          end else begin
            wr_en        = 1'b1;
            wr_addr      = '0;
            wr_cnt_nxt   = one_idx;
            wr_state_nxt = FILL;
          end
        end
      end
      FILL: begin
        if (din_valid) begin
          wr_en = 1'b1;
          if (din_sof) begin
            // Early sof: abandon partial frame, restart same bank at slot 0.
            err_nxt    = 1'b1;
            wr_addr    = '0;
            wr_cnt_nxt = one_idx;
          end else if (wr_cnt == last_idx) begin
            wr_done      = 1'b1;
            wr_cnt_nxt   = '0;
            wr_bank_nxt  = ~wr_bank;
            wr_state_nxt = WAIT_SOF;
          end else begin
            wr_cnt_nxt = wr_cnt + one_idx;
          end
        end
      end
      default: wr_state_nxt = WAIT_SOF;
    endcase
  end

  // ---------------------------------------------------------------
  // Read FSM: sweep a full bank linearly
  // ---------------------------------------------------------------
  // IDLE issues address 0 in the same cycle it sees a full bank, so the
  // first read lands one cycle after the last write (rd_cnt is 0 in IDLE).
  always_comb begin
    rd_state_nxt = rd_state;
    rd_cnt_nxt   = rd_cnt;
    rd_bank_nxt  = rd_bank;
    rd_en        = 1'b0;
    rd_done      = 1'b0;
    case (rd_state)
      IDLE: begin
        if (bank_full[rd_bank]) begin
          rd_en        = 1'b1;
          rd_cnt_nxt   = one_idx;
          rd_state_nxt = READ;
        end
      end
      READ: begin
        rd_en = 1'b1;
        if (rd_cnt == last_idx) begin
          rd_done     = 1'b1;
          rd_cnt_nxt  = '0;
          rd_bank_nxt = ~rd_bank;
          // Continue gaplessly if the other bank is full or completes now.
          if (bank_full[~rd_bank] || (wr_done && (wr_bank != rd_bank))) begin
            rd_state_nxt = READ;
          end else begin
            rd_state_nxt = IDLE;
          end
        end else begin
          rd_cnt_nxt = rd_cnt + one_idx;
        end
      end
      default: rd_state_nxt = IDLE;
    endcase
  end

  // Set wins over clear; they never target the same bank in one cycle.
  always_comb begin
    bank_full_nxt = bank_full;
    if (rd_done) bank_full_nxt[rd_bank] = 1'b0;
    if (wr_done) bank_full_nxt[wr_bank] = 1'b1;
  end

  // ---------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      wr_state  <= WAIT_SOF;
      wr_cnt    <= '0;
      wr_bank   <= 1'b0;
      rd_state  <= IDLE;
      rd_cnt    <= '0;
      rd_bank   <= 1'b0;
      bank_full <= 2'b00;
    end else if (sys_en) begin
      wr_state  <= wr_state_nxt;
      wr_cnt    <= wr_cnt_nxt;
      wr_bank   <= wr_bank_nxt;
      rd_state  <= rd_state_nxt;
      rd_cnt    <= rd_cnt_nxt;
      rd_bank   <= rd_bank_nxt;
      bank_full <= bank_full_nxt;
    end
  end

  // ---------------------------------------------------------------
  // RAM write port
  // ---------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (sys_en && wr_en) begin
      mem[{wr_bank, wr_addr}] <= {din_r, din_i};
    end
  end

  // ---------------------------------------------------------------
  // Registered read and output strobes (aligned with read data)
  // ---------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      dout_r     <= '0;
      dout_i     <= '0;
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      dout_eof   <= 1'b0;
      frame_err  <= 1'b0;
    end else if (sys_en) begin
      if (rd_en) begin
        {dout_r, dout_i} <= mem[{rd_bank, rd_cnt}];
      end
      dout_valid <= rd_en;
      dout_sof   <= rd_en && (rd_cnt == '0);
      dout_eof   <= rd_en && (rd_cnt == last_idx);
      frame_err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_r22sdf_bitrev_reorder.sv
// Bench for r22sdf_bitrev_reorder with N=16: a frame-level model schedules the
// natural-order output stream in enabled-cycle time; a negedge process compares
// every output each cycle, and a few literal checks pin the model.
module tb_r22sdf_bitrev_reorder;
  localparam int DW = 16;
  localparam int N  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n, en, din_valid, din_sof;
  logic [DW-1:0] din_r, din_i;
  logic          dout_valid, dout_sof, dout_eof, frame_err;
  logic [DW-1:0] dout_r, dout_i;

  always #5 clk = ~clk;

  r22sdf_bitrev_reorder #(.data_resolution(DW), .fft_length(N)) dut (
    .sys_clk(clk), .sys_nrst(rst_n), .sys_en(en),
    .din_valid(din_valid), .din_sof(din_sof), .din_r(din_r), .din_i(din_i),
    .dout_valid(dout_valid), .dout_sof(dout_sof), .dout_eof(dout_eof),
    .dout_r(dout_r), .dout_i(dout_i), .frame_err(frame_err)
  );

  function automatic int brev(input int v);
    int r = 0;
    for (int b = 0; b < AW; b++) r |= ((v >> b) & 1) << (AW - 1 - b);
    return r;
  endfunction

  typedef struct { int at; logic [DW-1:0] r; logic [DW-1:0] i; bit sof; bit eof; } exp_t;
  exp_t expq[$];

  int vectors = 0, miscompares = 0;
  int ecount = 0, err_at = -1, last_end = 0, last_done_at = 0, pos = 0;
  bit in_frame = 0, last_en = 1;
  logic [DW-1:0] fr[N], fi[N];

  // Observed stream (enabled cycles only) for literal checks.
  int obs_at[$];
  logic [DW-1:0] obs_r[$], obs_i[$];
  int err_seen = 0;

  // Frame model: collect a frame, then schedule its natural-order replay at
  // the first enabled edge after completion or right after the previous frame.
  always @(posedge clk) begin
    if (!rst_n) begin
      expq.delete();
      in_frame = 0; pos = 0; err_at = -1; last_end = 0; last_en = 1;
    end else if (en) begin
      ecount++;
      last_en = 1;
      if (din_valid) begin
        if (din_sof) begin
          if (in_frame) err_at = ecount;
          fr[0] = din_r; fi[0] = din_i; pos = 1; in_frame = 1;
        end else if (in_frame) begin
          fr[pos] = din_r; fi[pos] = din_i; pos++;
          if (pos == N) begin
            int start;
            exp_t e;
            start = (ecount + 1 > last_end + 1) ? ecount + 1 : last_end + 1;
            for (int k = 0; k < N; k++) begin
              e.at = start + k; e.r = fr[brev(k)]; e.i = fi[brev(k)];
              e.sof = (k == 0); e.eof = (k == N - 1);
              expq.push_back(e);
            end
            last_end = start + N - 1;
            last_done_at = ecount;
            in_frame = 0;
          end
        end
      end
    end else begin
      last_en = 0;
    end
  end

  // Per-cycle compare.
  logic [DW-1:0] hold_r = '0, hold_i = '0;
  logic [2*DW+3:0] pexp = '0;
  always @(negedge clk) begin
    logic [2*DW+3:0] ex, act;
    if (!rst_n) begin
      hold_r = '0; hold_i = '0;
      ex = '0;
    end else if (!last_en) begin
      ex = pexp;
    end else begin
      ex = {1'b0, 1'b0, 1'b0, hold_r, hold_i, (err_at == ecount)};
      if (expq.size() > 0 && expq[0].at == ecount) begin
        exp_t e;
        e = expq.pop_front();
        hold_r = e.r; hold_i = e.i;
        ex = {1'b1, e.sof, e.eof, e.r, e.i, (err_at == ecount)};
      end
    end
    act = {dout_valid, dout_sof, dout_eof, dout_r, dout_i, frame_err};
    vectors++;
    if (act !== ex) begin
      miscompares++;
      $display("FAIL cycle %0d: {valid,sof,eof,r,i,err} got %h expected %h", ecount, act, ex);
    end
    pexp = ex;
    if (rst_n && last_en) begin
      if (dout_valid) begin obs_at.push_back(ecount); obs_r.push_back(dout_r); obs_i.push_back(dout_i); end
      if (frame_err) err_seen++;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input bit sof, input logic [DW-1:0] r, input logic [DW-1:0] i);
    din_valid = 1'b1; din_sof = sof; din_r = r; din_i = i;
    tick();
    din_valid = 1'b0; din_sof = 1'b0;
  endtask

  // mode 0: random data, mode 1: value bitrev(n) on both components
  task automatic send_frame(input int mode, input int gap);
    for (int n = 0; n < N; n++) begin
      if (mode == 1) send(n == 0, DW'(brev(n)), DW'(brev(n)));
      else           send(n == 0, DW'($urandom), DW'($urandom));
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic clear_obs();
    obs_at.delete(); obs_r.delete(); obs_i.delete(); err_seen = 0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; din_valid = 1'b0; din_sof = 1'b0; din_r = '0; din_i = '0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Single frame carrying bitrev(n): natural output must be 0..15.
    clear_obs();
    send_frame(1, 0);
    idle(25);
    check("single_count", obs_r.size(), 16);
    for (int k = 0; k < 16 && k < obs_r.size(); k++) begin
      check("single_r", obs_r[k], k);
      check("single_i", obs_i[k], k);
    end
    if (obs_at.size() > 0) check("single_latency", obs_at[0] - last_done_at, 1);

    // Three gapless frames: 48 contiguous outputs, no errors.
    clear_obs();
    repeat (3) send_frame(0, 0);
    idle(40);
    check("b2b_count", obs_r.size(), 48);
    if (obs_at.size() == 48) check("b2b_contiguous", obs_at[47] - obs_at[0], 47);
    check("b2b_err", err_seen, 0);

    // Valid every other cycle: each frame is still one 16-cycle burst.
    clear_obs();
    repeat (2) send_frame(0, 1);
    idle(40);
    check("sparse_count", obs_r.size(), 32);

    // Early sof at sample 7: one error pulse, only the complete frame emerges.
    clear_obs();
    for (int n = 0; n < 7; n++) send(n == 0, DW'($urandom), DW'($urandom));
    send_frame(0, 0);
    idle(30);
    check("early_sof_err", err_seen, 1);
    check("early_sof_count", obs_r.size(), 16);

    // Enable held low mid-readout.
    clear_obs();
    send_frame(0, 0);
    idle(6);
    en = 1'b0;
    idle(5);
    en = 1'b1;
    idle(30);
    check("stall_count", obs_r.size(), 16);

    // Asynchronous reset mid-readout.
    send_frame(0, 0);
    idle(5);
    #2 rst_n = 1'b0;
    #1 check("async_rst_outputs", {dout_valid, dout_sof, dout_eof, dout_r, dout_i, frame_err}, 0);
    tick();
    rst_n = 1'b1;
    clear_obs();
    for (int n = 0; n < 5; n++) send(1'b0, DW'($urandom), DW'($urandom));
    idle(5);
    check("no_sof_ignored", obs_r.size(), 0);
    send_frame(0, 0);
    idle(30);
    check("post_rst_count", obs_r.size(), 16);

    // Randomized gaps and stray non-sof samples.
    for (int f = 0; f < 4; f++) begin
      repeat ($urandom_range(0, 2)) send(1'b0, DW'($urandom), DW'($urandom));
      send_frame(0, $urandom_range(0, 2));
    end
    idle(60);
    check("queue_drained", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/r22sdf_bitrev_reorder.md
Name: r22sdf_bitrev_reorder

Overview:
- Output reorder stage placed directly downstream of the 16384-pt R2²SDF FFT pipeline.
- The FFT emits bins in bit-reversed index order. This block buffers each frame in a ping-pong RAM and replays it in natural bin order (0..N-1).
- It also produces frame-boundary strobes for downstream consumers.
- Streaming only, no backpressure: throughput is 1 sample/cycle in and out.

Parameters:
- data_resolution, 16, bit width of each real/imag sample.
- fft_length, 16384, frame length N; power of two, ≥4.
- addr_w (localparam), $clog2(fft_length), RAM address width.

Ports:
- sys_clk  in  1  single clock, rising edge.
- sys_nrst  in  1  asynchronous, active-low reset.
- sys_en  in  1  global clock enable; when low, all state and outputs freeze.
- din_valid  in  1  din_r/din_i carry a sample this cycle.
- din_sof  in  1  qualified by din_valid; marks bit-reversed sample index 0 of a frame.
- din_r  in  data_resolution  real part, bit-reversed order.
- din_i  in  data_resolution  imag part, bit-reversed order.
- dout_valid  out  1  dout_r/dout_i valid.
- dout_sof  out  1  with dout_valid, natural bin 0.
- dout_eof  out  1  with dout_valid, natural bin N-1.
- dout_r  out  data_resolution  real part, natural order.
- dout_i  out  data_resolution  imag part, natural order.
- frame_err  out  1  one-cycle pulse on a framing/overrun fault.

Behaviour:
- Reset (sys_nrst low, asynchronous): all outputs 0.
  - Write FSM goes to WAIT_SOF; read FSM goes to IDLE.
  - Both bank_full flags clear; wr_bank=0; counters 0.
  - RAM contents are don't-care.
- sys_en low: no register, counter or RAM write changes; outputs hold their last values.
  - Every cycle statement below counts only enabled cycles.
- Storage: two banks of N complex words each (2·N·2·data_resolution bits). Inferred dual-port RAM with a registered read.
- Write FSM:
  - WAIT_SOF: din_valid without din_sof is ignored. On din_valid & din_sof, write the sample to address bitrev(0)=0 of wr_bank, set wr_cnt=1, go to FILL.
  - FILL: on each din_valid, write to address bitrev(wr_cnt) of wr_bank, where bitrev reverses all addr_w bits, then wr_cnt++.
  - On the write with wr_cnt=N-1: set bank_full[wr_bank], toggle wr_bank, go to WAIT_SOF.
  - A new frame may start on the very next cycle.
  - din_sof in FILL with wr_cnt≠0: pulse frame_err and discard the partial frame. Restart in the same bank, writing this sample at address 0 with wr_cnt=1.
  - Overrun: a sof arrives while bank_full[wr_bank] is still set. Pulse frame_err, drop the whole frame, stay in WAIT_SOF. With sys_en shared by both sides this cannot occur, because reading N words takes exactly N cycles; it is covered for robustness.
- Read FSM:
  - IDLE: when bank_full[rd_bank] is set, go to READ with rd_cnt=0.
  - READ: issue read address rd_cnt of rd_bank each cycle, then rd_cnt++.
  - At rd_cnt=N-1: clear bank_full[rd_bank] and toggle rd_bank.
  - If the other bank is already full, continue in READ with rd_cnt=0 (no gap); else go to IDLE.
- Output timing:
  - RAM data is registered one cycle after the address. dout_valid/dout_sof/dout_eof are pipelined to match.
  - The last input write of a frame occurs in cycle T; bank_full is visible at T+1; address 0 is issued at T+1; dout_valid with dout_sof is asserted at T+2.
  - Total latency from last input to first output is 2 cycles. Each frame then outputs N contiguous cycles.
  - When not valid, dout_r/dout_i hold their last value; dout_sof/dout_eof are 0.
- Simultaneous events: a write completing into bank A and a read finishing bank B in the same cycle are both honoured; the read continues immediately into A.
- No arithmetic or scaling; data is passed bit-exact.

Test Plan:
- fft_length=16, single frame; sample n carries value bitrev4(n) on both components, with din_sof at n=0 → dout values 0,1,…,15 on 16 contiguous cycles; dout_sof on 0, dout_eof on 15; first dout_valid 2 cycles after the last input.
- Three back-to-back gapless frames (N=16) → 48 contiguous dout_valid cycles, correct natural order per frame, sof/eof every 16 cycles, frame_err never pulses.
- Input with din_valid every other cycle → each frame output as one 16-cycle contiguous burst starting 2 cycles after its last input.
- din_sof reasserted at sample 7 → frame_err pulses for one cycle, the partial frame produces no output, and the following complete frame is reordered correctly.
- sys_en held low for 5 cycles mid-readout → dout_* hold their values; readout resumes with no lost or duplicated bins and eof still lands on bin 15.
- sys_nrst pulsed low mid-readout → all outputs 0 asynchronously; din_valid without din_sof is ignored afterwards; the next sof-framed frame outputs correctly.
